// File: rtl/router_arbiter.sv
// router_arbiter: three buffered inputs (east, west, inject) steered by destination id
// to three registered outputs (east, west, scheduler) with per-output round-robin arbitration.
`default_nettype none

module router_arbiter #(
    parameter int PKT_W      = 34,
    parameter int ID_W       = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ID_W-1:0]  core_id,
    input  logic [PKT_W-1:0] east_in_pkt,
    input  logic             east_in_valid,
    output logic             east_in_ready,
    input  logic [PKT_W-1:0] west_in_pkt,
    input  logic             west_in_valid,
    output logic             west_in_ready,
    input  logic [PKT_W-1:0] inj_pkt,
    input  logic             inj_valid,
    output logic             inj_ready,
    output logic [PKT_W-1:0] east_out_pkt,
    output logic             east_out_valid,
    input  logic             east_out_ready,
    output logic [PKT_W-1:0] west_out_pkt,
    output logic             west_out_valid,
    input  logic             west_out_ready,
    output logic [PKT_W-1:0] sched_pkt,
    output logic             sched_valid,
    input  logic             sched_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Source index: 0 east, 1 west, 2 inject. Output index: 0 east, 1 west, 2 sched.
    logic [PKT_W-1:0] src_pkt   [3];
    logic [PKT_W-1:0] head      [3];
    logic [ID_W-1:0]  dest      [3];
    logic [2:0]       src_valid;
    logic [2:0]       src_ready;
    logic [2:0]       not_full;
    logic [2:0]       not_empty;
    logic [2:0]       push;
    logic [2:0]       pop;
    logic             ready_en;

    logic [2:0]       req       [3];
    logic [1:0]       rr_ptr    [3];
    logic [1:0]       gnt_idx   [3];
    logic [2:0]       load;
    logic [2:0]       out_valid;
    logic [2:0]       out_ready;
    logic [PKT_W-1:0] out_pkt   [3];

    assign src_pkt[0]   = east_in_pkt;
    assign src_pkt[1]   = west_in_pkt;
    assign src_pkt[2]   = inj_pkt;
    assign src_valid    = {inj_valid, west_in_valid, east_in_valid};
    // ready_en keeps every input closed while reset is held and for the first edge after it.
    assign src_ready    = not_full & {3{ready_en}};
    assign push         = src_valid & src_ready;
    assign east_in_ready = src_ready[0];
    assign west_in_ready = src_ready[1];
    assign inj_ready     = src_ready[2];

    generate
        for (genvar i = 0; i < 3; i++) begin : g_fifo
            logic [PKT_W-1:0] mem [FIFO_DEPTH];
            logic [PTR_W-1:0] wr_ptr;
            logic [PTR_W-1:0] rd_ptr;
            logic [CNT_W-1:0] count;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end else begin
                    if (push[i]) wr_ptr <= wr_ptr + 1'b1;
                    if (pop[i])  rd_ptr <= rd_ptr + 1'b1;
                    case ({push[i], pop[i]})
                        2'b10:   count <= count + 1'b1;
                        2'b01:   count <= count - 1'b1;
                        default: count <= count;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (push[i]) mem[wr_ptr] <= src_pkt[i];
            end

            assign head[i]      = mem[rd_ptr];
            assign dest[i]      = head[i][PKT_W-1 -: ID_W];
            assign not_empty[i] = (count != '0);
            assign not_full[i]  = (count != CNT_W'(FIFO_DEPTH));
        end
    endgenerate

    always_comb begin
        for (int o = 0; o < 3; o++) req[o] = '0;
        for (int i = 0; i < 3; i++) begin
            if (not_empty[i]) begin
                if (dest[i] == core_id)     req[2][i] = 1'b1;
                else if (dest[i] > core_id) req[0][i] = 1'b1;
                else                        req[1][i] = 1'b1;
            end
        end
    end

    // Scan from rr_ptr+2 down to rr_ptr so the candidate nearest rr_ptr wins.
    always_comb begin
        logic [1:0] cand;
        cand = 2'd0;
        pop  = '0;
        load = '0;
        for (int o = 0; o < 3; o++) begin
            gnt_idx[o] = 2'd0;
            for (int k = 2; k >= 0; k--) begin
                cand = 2'((int'(rr_ptr[o]) + k) % 3);
                if (req[o][cand]) gnt_idx[o] = cand;
            end
            load[o] = (|req[o]) && (!out_valid[o] || out_ready[o]);
            if (load[o]) pop[gnt_idx[o]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en <= 1'b0;
            for (int o = 0; o < 3; o++) begin
                out_valid[o] <= 1'b0;
                out_pkt[o]   <= '0;
                rr_ptr[o]    <= 2'd0;
            end
        end else begin
            ready_en <= 1'b1;
            for (int o = 0; o < 3; o++) begin
                if (load[o]) begin
                    out_valid[o] <= 1'b1;
                    out_pkt[o]   <= head[gnt_idx[o]];
                    rr_ptr[o]    <= (gnt_idx[o] == 2'd2) ? 2'd0 : gnt_idx[o] + 2'd1;
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end

    assign out_ready      = {sched_ready, west_out_ready, east_out_ready};
    assign east_out_pkt   = out_pkt[0];
    assign west_out_pkt   = out_pkt[1];
    assign sched_pkt      = out_pkt[2];
    assign east_out_valid = out_valid[0];
    assign west_out_valid = out_valid[1];
    assign sched_valid    = out_valid[2];

endmodule

`default_nettype wire
